// File: rtl/event_sync_unit.sv
// ============================================================================
// Module   : event_sync_unit
// Brief    : Synchronises 32 async event lines into HCLK pulses with per-line
//            edge select, SW trigger and level status over APB. Optional
//            debounce filter enabled by defining EVENT_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module event_sync_unit #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [31:0]               event_i,
  output logic [31:0]               event_o
);

  localparam logic [1:0] c_ADDR_RISE   = 2'd0;
  localparam logic [1:0] c_ADDR_FALL   = 2'd1;
  localparam logic [1:0] c_ADDR_STATUS = 2'd2;

  logic [SYNC_STAGES-1:0][31:0] r_sync;
  logic [31:0] r_rise;
  logic [31:0] r_fall;
  logic [31:0] r_swtrig;
  logic [31:0] r_prev;
  logic [31:0] r_event;
  logic [31:0] w_sync;
  logic [31:0] w_lvl;
  logic [31:0] w_edge;
  logic [1:0]  w_addr;
  logic        w_apb_wr;
  logic        w_apb_rd;
  logic        w_unused_addr;

  assign w_addr        = PADDR[3:2];
  assign w_apb_wr      = PSEL & PENABLE & PWRITE;
  assign w_apb_rd      = PSEL & PENABLE & ~PWRITE;
  assign w_unused_addr = ^{PADDR[APB_ADDR_WIDTH-1:4], PADDR[1:0]};

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], event_i};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef EVENT_FILTER_EN
  localparam int                 c_CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILTER_LEN - 1);

  // The level only flips once the synchronised input has disagreed with it
  // for FILTER_LEN consecutive cycles; any agreement restarts the count.
  for (genvar gi = 0; gi < 32; gi++) begin : g_filter
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_lvl_bit;

    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        r_cnt     <= '0;
        r_lvl_bit <= 1'b0;
      end else if (w_sync[gi] != r_lvl_bit) begin
        if (r_cnt == c_CNT_LAST) begin
          r_lvl_bit <= w_sync[gi];
          r_cnt     <= '0;
        end else begin
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end

    assign w_lvl[gi] = r_lvl_bit;
  end
`else
  logic [31:0] r_lvl;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_lvl <= '0;
    end else begin
      r_lvl <= w_sync;
    end
  end

  assign w_lvl = r_lvl;
`endif

  // prev follows lvl unconditionally so enabling an edge never sees a stale level.
  assign w_edge = (r_rise & w_lvl & ~r_prev) | (r_fall & ~w_lvl & r_prev);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rise   <= '0;
      r_fall   <= '0;
      r_swtrig <= '0;
      r_prev   <= '0;
      r_event  <= '0;
    end else begin
      if (w_apb_wr && (w_addr == c_ADDR_RISE)) begin
        r_rise <= PWDATA;
      end
      if (w_apb_wr && (w_addr == c_ADDR_FALL)) begin
        r_fall <= PWDATA;
      end
      r_swtrig <= (w_apb_wr && (w_addr == 2'd3)) ? PWDATA : 32'd0;
      r_prev   <= w_lvl;
      r_event  <= w_edge | r_swtrig;
    end
  end

  assign event_o = r_event;

  always_comb begin
    PRDATA = '0;
    if (w_apb_rd) begin
      case (w_addr)
        c_ADDR_RISE:   PRDATA = r_rise;
        c_ADDR_FALL:   PRDATA = r_fall;
        c_ADDR_STATUS: PRDATA = w_lvl;
        default:       PRDATA = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_event_sync_unit.sv
// ============================================================================
// Module   : tb_event_sync_unit
// Brief    : Scoreboard bench for event_sync_unit (expected pulses queued by
//            stimulus, checked by an independent monitor on event_o).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_event_sync_unit;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 4;
`ifdef EVENT_FILTER_EN
  localparam int LAT = SYNC_STAGES + 2 + FILTER_LEN - 1;
`else
  localparam int LAT = SYNC_STAGES + 2;
`endif

  logic        HCLK;
  logic        HRESETn;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] event_i;
  logic [31:0] event_o;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b1;

  event_sync_unit #(
    .APB_ADDR_WIDTH(12),
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_LEN    (FILTER_LEN)
  ) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PWRITE (PWRITE),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR),
    .event_i(event_i),
    .event_o(event_o)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) cyc <= cyc + 1;

  // Every non-zero event_o cycle must match the oldest queued expectation.
  always @(negedge HCLK) begin
    if (mon_en && HRESETn && (event_o != 32'd0)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got 0x%08h at cycle %0d, expected none", event_o, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ((e.val !== event_o) || (e.cyc != cyc)) begin
          errors++;
          $display("FAIL pulse: got 0x%08h at cycle %0d, expected 0x%08h at cycle %0d",
                   event_o, cyc, e.val, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] val, input int at);
    exp_t e;
    e.val = val;
    e.cyc = at;
    q.push_back(e);
  endtask

  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    @(negedge HCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
    @(negedge HCLK);
    PENABLE = 1'b1;
    if (addr[3:2] == 2'd3) push(data, cyc + 2);
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input string name, input logic [11:0] addr, input logic [31:0] exp);
    @(negedge HCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
    @(negedge HCLK);
    PENABLE = 1'b1;
    #1 chk(name, PRDATA, exp);
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  initial begin
    HRESETn = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; event_i = '0;
    #1;
    chk("reset_event_o", event_o, 32'd0);
    chk("reset_prdata", PRDATA, 32'd0);
    chk("pready", {31'd0, PREADY}, 32'd1);
    chk("pslverr", {31'd0, PSLVERR}, 32'd0);
    idle(3);
    HRESETn = 1'b1;
    idle(2);
    apb_read("reset_rise", 12'h000, 32'd0);
    apb_read("reset_fall", 12'h004, 32'd0);
    apb_read("reset_status", 12'h008, 32'd0);

    // Rising edge on line 0
    apb_write(12'h000, 32'h1);
    @(negedge HCLK);
    event_i[0] = 1'b1;
    push(32'h1, cyc + LAT);
    idle(LAT + 6);
    apb_read("status_line0", 12'h008, 32'h1);

    // Falling-only on line 31: the 0->1 must stay silent
    apb_write(12'h004, 32'h8000_0000);
    apb_write(12'h000, 32'h0);
    @(negedge HCLK);
    event_i[31] = 1'b1;
    idle(LAT + 4);
    event_i[31] = 1'b0;
    push(32'h8000_0000, cyc + LAT);
    idle(LAT + 6);

    // Software trigger, then SWTRIG reads back zero
    apb_write(12'h00C, 32'hA5);
    idle(3);
    apb_read("swtrig_read", 12'h00C, 32'd0);
    apb_write(12'h008, 32'hFFFF_FFFF);
    apb_read("status_ro", 12'h008, 32'h1);

    // Both edges enabled on lines 3 and 4
    apb_write(12'h000, 32'h18);
    apb_write(12'h004, 32'h18);
    @(negedge HCLK);
    event_i[3] = 1'b1;
    push(32'h8, cyc + LAT);
    idle(LAT + 4);
    event_i[3] = 1'b0;
    push(32'h8, cyc + LAT);
    idle(LAT + 6);

`ifdef EVENT_FILTER_EN
    // Debounce: a short glitch is swallowed, a long enough pulse is not
    apb_write(12'h000, 32'h4);
    apb_write(12'h004, 32'h0);
    @(negedge HCLK);
    event_i[2] = 1'b1;
    idle(FILTER_LEN - 1);
    event_i[2] = 1'b0;
    idle(LAT + 8);
    event_i[2] = 1'b1;
    push(32'h4, cyc + LAT);
    idle(FILTER_LEN);
    event_i[2] = 1'b0;
    idle(LAT + 8);
`else
    // Line 4 toggling every cycle gives back-to-back pulses
    for (int k = 0; k < 4; k++) begin
      @(negedge HCLK);
      event_i[4] = ~event_i[4];
      push(32'h10, cyc + LAT);
    end
    idle(LAT + 6);
`endif

    // Reset in the middle of a toggle burst on lines 7:0
    apb_write(12'h000, 32'hFF);
    apb_write(12'h004, 32'hFF);
    mon_en = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge HCLK);
      event_i[7:0] = ~event_i[7:0];
    end
    #3;
    HRESETn = 1'b0;
    q.delete();
    #1 chk("reset_mid_burst", event_o, 32'd0);
    event_i = 32'h20;
    idle(4);
    HRESETn = 1'b1;
    mon_en = 1'b1;
    idle(LAT + 6);
    apb_read("rise_after_reset", 12'h000, 32'd0);
    apb_read("fall_after_reset", 12'h004, 32'd0);
    apb_read("status_after_reset", 12'h008, 32'h20);

    // Line 5 was high through reset: enabling RISE must not fire
    apb_write(12'h000, 32'h20);
    idle(LAT + 6);
    event_i[5] = 1'b0;
    idle(LAT + 6);
    event_i[5] = 1'b1;
    push(32'h20, cyc + LAT);
    idle(LAT + 8);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
